// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path: deframer states, E0 prefix, parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;

  // True when the 8 data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Byte-strobe bus between the PS/2 receive FIFO and its consumer (keyboard-matrix block).
interface ps2_rx_fifo_if;
  logic [7:0] DATA;
  logic       DONE;
  logic       EXTENDED;
  logic       hold;

  modport master (output DATA, output DONE, output EXTENDED, input hold);
  modport slave  (input DATA, input DONE, input EXTENDED, output hold);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for PS2_CLK/PS2_DATA on the clk_en grid, plus PS2_CLK falling-edge pulse.
module ps2_sync_edge (
  input  logic clk,
  input  logic nRESET,
  input  logic clk_en,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  output logic clk_fall,
  output logic data_sync
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Idle PS/2 lines sit high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else if (clk_en) begin
      clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
      data_sync_q <= {data_sync_q[0], PS2_DATA};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_fall  = clk_prev_q & ~clk_sync_q[1];
  assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host deframer with parity/stop/timeout checks, byte FIFO and DONE strobe output.
// Optional E0-prefix tagging onto EXTENDED is built when PS2_EXT_TAG_EN is defined.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT_TICKS = 2048
) (
  input  logic               clk,
  input  logic               nRESET,
  input  logic               clk_en,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  input  logic               err_clr,
  ps2_rx_fifo_if.master      bus,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned TmrW  = $clog2(TIMEOUT_TICKS + 1);
`ifdef PS2_EXT_TAG_EN
  localparam int unsigned EntryW = 9;
`else
  localparam int unsigned EntryW = 8;
`endif
  localparam logic [AddrW:0] PtrOne = 1;

  logic clk_fall, data_s;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .nRESET    (nRESET),
    .clk_en    (clk_en),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .clk_fall  (clk_fall),
    .data_sync (data_s)
  );

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmrW-1:0] cnt_q, cnt_d;
  logic            push, perr_set, ferr_set;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    if (clk_en) begin
      if (clk_fall) begin
        cnt_d = '0;
        unique case (state_q)
          StIdle: begin
            if (!data_s) begin
              state_d   = StShift;
              bit_cnt_d = 3'd0;
            end
          end
          StShift: begin
            shift_d   = {data_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = StParity;
          end
          StParity: begin
            par_d   = data_s;
            state_d = StStop;
          end
          StStop: begin
            state_d = StIdle;
            if (!data_s)                            ferr_set = 1'b1;
            else if (odd_parity_ok({par_q, shift_q})) push     = 1'b1;
            else                                    perr_set = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end else if (state_q != StIdle) begin
        if (cnt_q >= TmrW'(TIMEOUT_TICKS - 1)) begin
          // Stalled frame: abandon it and leave the counter saturated.
          state_d  = StIdle;
          ferr_set = 1'b1;
          cnt_d    = TmrW'(TIMEOUT_TICKS);
        end else begin
          cnt_d = cnt_q + TmrW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      cnt_q     <= cnt_d;
    end
  end

  logic              push_fifo;
  logic [EntryW-1:0] entry;

`ifdef PS2_EXT_TAG_EN
  logic ext_pending_q, ext_pending_d;

  always_comb begin
    ext_pending_d = ext_pending_q;
    push_fifo     = 1'b0;
    entry         = {ext_pending_q, shift_q};
    if (push) begin
      if (shift_q == PS2_EXT_PREFIX) begin
        ext_pending_d = 1'b1;
      end else begin
        push_fifo     = 1'b1;
        ext_pending_d = 1'b0;
      end
    end
    if (perr_set || ferr_set) ext_pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) ext_pending_q <= 1'b0;
    else         ext_pending_q <= ext_pending_d;
  end
`else
  assign push_fifo = push;
  assign entry     = shift_q;
`endif

  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW:0]    wptr_q, rptr_q;
  logic              empty, full, pop, do_write, ovf_set;
  logic [EntryW-1:0] head;
  logic [7:0]        data_q;
  logic              ext_q, done_q;
  logic              perr_q, ferr_q, ovf_q;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                    (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign head     = mem_q[rptr_q[AddrW-1:0]];
  assign pop      = clk_en && !done_q && !empty && !bus.hold;
  // A pop on the same tick frees the slot, so a push into a full FIFO still lands.
  assign do_write = push_fifo && (!full || pop);
  assign ovf_set  = push_fifo && full && !pop;

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wptr_q[AddrW-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      data_q <= '0;
      ext_q  <= 1'b0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (clk_en) begin
      if (do_write) wptr_q <= wptr_q + PtrOne;
      if (pop) begin
        rptr_q <= rptr_q + PtrOne;
        data_q <= head[7:0];
`ifdef PS2_EXT_TAG_EN
        ext_q  <= head[8];
`endif
      end
      done_q <= pop;
      perr_q <= (perr_q & ~err_clr) | perr_set;
      ferr_q <= (ferr_q & ~err_clr) | ferr_set;
      ovf_q  <= (ovf_q  & ~err_clr) | ovf_set;
    end
  end

  assign bus.DATA     = data_q;
  assign bus.DONE     = done_q;
`ifdef PS2_EXT_TAG_EN
  assign bus.EXTENDED = ext_q;
`else
  assign bus.EXTENDED = 1'b0;
`endif
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: drives PS/2 frames on the pins and checks the DONE byte stream.
module tb_ps2_rx_fifo;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 64;
  localparam int unsigned Half  = 8;

  logic clk = 1'b0;
  logic nRESET, clk_en, PS2_CLK, PS2_DATA, err_clr;
  logic parity_err, frame_err, overflow;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(
    .FIFO_DEPTH    (Depth),
    .TIMEOUT_TICKS (Tmo)
  ) dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .clk_en     (clk_en),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .err_clr    (err_clr),
    .bus        (bus),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         tick = 0;
  int         last_done_tick = 0;
  int         done_count = 0;
  int         gap_seen = 0;
  logic       chk_gap = 1'b0;
  logic       done_prev = 1'b0;
  logic       ext_pend = 1'b0;
  logic [8:0] exp_q[$];

  always @(posedge clk) tick <= tick + 1;

  // Output monitor: every DONE pops one expected {EXTENDED, DATA} entry.
  always @(negedge clk) begin
    logic [8:0] e;
    if (nRESET && bus.DONE) begin
      checks++;
      if (done_prev) begin
        errors++;
        $display("FAIL done_width: DONE high on consecutive ticks, required one tick");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: DATA=%02h EXTENDED=%0b with no byte expected",
                 bus.DATA, bus.EXTENDED);
      end else begin
        e = exp_q.pop_front();
        if ({bus.EXTENDED, bus.DATA} !== e) begin
          errors++;
          $display("FAIL scoreboard: got EXT=%0b DATA=%02h, required EXT=%0b DATA=%02h",
                   bus.EXTENDED, bus.DATA, e[8], e[7:0]);
        end
      end
      if (chk_gap && gap_seen > 0) begin
        checks++;
        if (tick - last_done_tick != 2) begin
          errors++;
          $display("FAIL done_gap: %0d ticks between DONEs, required 2", tick - last_done_tick);
        end
      end
      if (chk_gap) gap_seen++;
      last_done_tick = tick;
      done_count++;
    end
    done_prev = nRESET && bus.DONE;
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] d);
`ifdef PS2_EXT_TAG_EN
    if (d == 8'hE0) begin
      ext_pend = 1'b1;
    end else begin
      exp_q.push_back({ext_pend, d});
      ext_pend = 1'b0;
    end
`else
    exp_q.push_back({1'b0, d});
`endif
  endtask

  task automatic send_bit(input logic b);
    PS2_DATA = b;
    wait_ticks(Half);
    PS2_CLK = 1'b0;
    wait_ticks(Half);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    logic par;
    par = ~(^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    PS2_DATA = 1'b1;
    wait_ticks(2 * Half);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_ticks(1);
    err_clr = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    nRESET   = 1'b0;
    clk_en   = 1'b1;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    err_clr  = 1'b0;
    bus.hold = 1'b0;
    wait_ticks(3);
    checks++;
    if (bus.DATA !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %02h, required 00", bus.DATA);
    end
    check_bit("reset_done", bus.DONE, 1'b0);
    check_bit("reset_ext", bus.EXTENDED, 1'b0);
    check_bit("reset_parity_err", parity_err, 1'b0);
    check_bit("reset_frame_err", frame_err, 1'b0);
    check_bit("reset_overflow", overflow, 1'b0);
    nRESET = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_good_frame();
    int n0;
    n0 = done_count;
    expect_byte(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_int("good_frame_done_count", done_count - n0, 1);
    check_bit("good_frame_parity_err", parity_err, 1'b0);
    check_bit("good_frame_frame_err", frame_err, 1'b0);
    checks++;
    if (bus.DATA !== 8'h1C) begin
      errors++;
      $display("FAIL good_frame_data_hold: got %02h, required 1C", bus.DATA);
    end
  endtask

  task automatic test_parity();
    int n0;
    n0 = done_count;
    send_frame(8'h1C, 1'b1, 1'b1);
    check_bit("parity_err_set", parity_err, 1'b1);
    check_int("parity_no_done", done_count - n0, 0);
    expect_byte(8'h1B);
    send_frame(8'h1B, 1'b0, 1'b1);
    check_int("parity_next_done", done_count - n0, 1);
    pulse_err_clr();
    check_bit("parity_err_clr", parity_err, 1'b0);
  endtask

  task automatic test_frame_err();
    int n0;
    n0 = done_count;
    send_frame(8'h33, 1'b0, 1'b0);
    check_bit("frame_err_stop", frame_err, 1'b1);
    check_int("frame_err_no_done", done_count - n0, 0);
    pulse_err_clr();
    check_bit("frame_err_clr", frame_err, 1'b0);
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    d = 8'h29;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    PS2_DATA = 1'b1;
    // Edge reaches the deframer 3 ticks after the pin falls.
    wait_ticks(Tmo + 2 - Half);
    check_bit("timeout_early", frame_err, 1'b0);
    wait_ticks(1);
    check_bit("timeout_exact", frame_err, 1'b1);
    pulse_err_clr();
    expect_byte(8'h29);
    send_frame(8'h29, 1'b0, 1'b1);
    check_bit("timeout_recover_ferr", frame_err, 1'b0);
    check_int("timeout_recover_queue", exp_q.size(), 0);
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5];
    int n0;
    bytes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    n0 = done_count;
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < Depth) expect_byte(bytes[i]);
      send_frame(bytes[i], 1'b0, 1'b1);
    end
    check_bit("overflow_set", overflow, 1'b1);
    check_int("overflow_held_no_done", done_count - n0, 0);
    chk_gap  = 1'b1;
    gap_seen = 0;
    bus.hold = 1'b0;
    wait_ticks(1);
    check_bit("hold_release_done", bus.DONE, 1'b1);
    wait_ticks(12);
    chk_gap = 1'b0;
    check_int("overflow_drain_count", done_count - n0, Depth);
    check_int("overflow_queue", exp_q.size(), 0);
    pulse_err_clr();
    check_bit("overflow_clr", overflow, 1'b0);
  endtask

  task automatic test_extended();
    int n0;
    n0 = done_count;
    expect_byte(8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_byte(8'h74);
    send_frame(8'h74, 1'b0, 1'b1);
`ifdef PS2_EXT_TAG_EN
    check_int("extended_done_count", done_count - n0, 1);
`else
    check_int("extended_done_count", done_count - n0, 2);
`endif
    check_int("extended_queue", exp_q.size(), 0);
  endtask

  task automatic test_reset_midframe();
    int n0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    nRESET = 1'b0;
    PS2_DATA = 1'b1;
    ext_pend = 1'b0;
    wait_ticks(2);
    check_bit("midreset_done", bus.DONE, 1'b0);
    nRESET = 1'b1;
    n0 = done_count;
    wait_ticks(4 * Half);
    check_int("midreset_no_done", done_count - n0, 0);
    check_bit("midreset_frame_err", frame_err, 1'b0);
    expect_byte(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_int("midreset_next_done", done_count - n0, 1);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_frame_err();
    test_timeout();
    test_overflow();
    test_extended();
    test_reset_midframe();
    wait_ticks(8);
    check_int("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Upstream PS/2 receive stage feeding the BBC keyboard-matrix block. It synchronises the raw PS2_CLK/PS2_DATA lines, deframes 11-bit device-to-host frames, and checks parity, stop bit and inter-bit timeout. Good bytes are buffered in a small FIFO and presented as a one-tick DATA/DONE strobe on the system clock-enable grid, the same form the matrix block samples with `if(clk_en) if(DONE)`.

## Interface
- FIFO_DEPTH, 4, byte entries; power of two, minimum 2.
- TIMEOUT_TICKS, 2048, clk_en ticks allowed between falling PS2_CLK edges inside a frame.
- clk  in  1  system clock.
- nRESET  in  1  reset, asynchronous assert, active-low; clears all state.
- clk_en  in  1  tick enable; all state except reset advances only when high.
- PS2_CLK  in  1  raw PS/2 clock line (asynchronous).
- PS2_DATA  in  1  raw PS/2 data line (asynchronous).
- hold  in  1  consumer stall; while high no new DONE is issued and the FIFO keeps filling.
- err_clr  in  1  on a clk_en tick, clears parity_err, frame_err and overflow.
- DATA  out  8  scan-code byte; valid while DONE is high.
- DONE  out  1  byte strobe, high for exactly one clk_en period.
- EXTENDED  out  1  byte was preceded by E0; only meaningful with the macro, otherwise tied 0.
- parity_err  out  1  sticky flag: a frame failed odd parity.
- frame_err  out  1  sticky flag: bad stop bit or timeout.
- overflow  out  1  sticky flag: a good byte arrived while the FIFO was full.

## Operation
- Synchroniser: 2 flops per line, clocked on clk_en ticks. A falling edge is synced CLK at 1 on the previous tick and 0 now.
- Deframer FSM, one transition per falling edge:
  - IDLE: DATA line 0 goes to SHIFT, bit count 0. DATA line 1 is ignored; stay in IDLE.
  - SHIFT: shift in LSB first. After 8 bits go to PARITY.
  - PARITY: latch the bit, go to STOP.
  - STOP: return to IDLE.
    - DATA line 1 and odd parity over the 9 bits: push the byte.
    - DATA line 1, parity bad: set parity_err, no push.
    - DATA line 0: set frame_err, no push.
- Timeout: a counter resets on every falling edge and counts ticks while not in IDLE. When it reaches TIMEOUT_TICKS, go to IDLE, set frame_err and discard the partial byte. The counter saturates and never wraps.
- FIFO: binary read/write pointers, each one bit wider than the address, so full and empty are distinguishable.
  - Push while full: drop the byte, set overflow, FIFO unchanged.
  - Push and pop on the same tick: both take effect, including when the FIFO is full.
- Output stage, evaluated each tick:
  - DONE low, FIFO not empty, hold low: load head into DATA/EXTENDED, set DONE, pop.
  - Otherwise: DONE goes low.
  - Result: at most one byte per 2 ticks. DATA holds its value after DONE falls.
- err_clr on the same tick as a new error: the new error wins and the flag stays set.

## Timing
- Reset values: DATA=0x00, DONE=0, EXTENDED=0, all flags 0, FSM IDLE, FIFO empty, counter 0.
- Edge detection latency: 2 ticks synchroniser plus 1 tick edge register after the pin falls.
- Push occurs on the tick the stop-bit edge is detected. DONE rises on the next tick, when the FIFO was empty and hold is low.
- hold deasserted: DONE rises on the same tick hold is seen low.
- Reset mid-frame or mid-strobe: immediate abort to reset values; no partial byte survives.

## Configuration
- PS2_EXT_TAG_EN defined:
  - A good byte 0xE0 is not pushed; it sets an ext_pending flag.
  - The next pushed byte carries EXTENDED=1 in a 9-bit FIFO entry, and ext_pending clears.
  - ext_pending also clears on any parity or frame error.
- PS2_EXT_TAG_EN undefined:
  - 0xE0 is pushed as ordinary data.
  - FIFO entries are 8 bits; EXTENDED is constant 0.

## Structure
- ps2_pkg holds:
  - the FSM state enum (IDLE, SHIFT, PARITY, STOP);
  - constant PS2_EXT_PREFIX = 8'hE0;
  - an odd-parity function over 9 bits.
- One sub-module, ps2_sync_edge: 2-flop synchroniser plus falling-edge pulse for PS2_CLK, and synchronised PS2_DATA. The FIFO stays inline.

## Test plan
- Valid frame carrying 0x1C (odd parity bit 0) -> exactly one DONE tick, DATA=0x1C, no flags.
- Frame 0x1C with parity bit 1 -> parity_err=1, no DONE; a following good frame 0x1B -> DONE with DATA=0x1B.
- Frame with stop bit 0 -> frame_err=1, no DONE. err_clr for one tick -> frame_err=0.
- Clock stops after 5 data bits -> frame_err set exactly TIMEOUT_TICKS ticks after the last edge; the next full frame 0x29 is received correctly.
- hold=1 and 5 frames 0x15,0x1D,0x24,0x2D,0x2C with FIFO_DEPTH=4 -> overflow=1. After hold=0: DONEs carry 15,1D,24,2D in order, 2 ticks apart.
- Frames E0,74 -> with PS2_EXT_TAG_EN: a single DONE, DATA=0x74, EXTENDED=1. Without it: two DONEs, 0xE0 then 0x74, EXTENDED=0.
